// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus arbiter: state encoding, timing
// defaults and small helpers used by the arbiter and its bench.
package spi_pkg;

   // Arbiter states, exposed on the debug port so checkers can bind to them.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      READY = 3'd2,
      START = 3'd3,
      XFER  = 3'd4,
      HOLD  = 3'd5
   } spi_state_t;

   // Default timing, in clk cycles.
   localparam int CS_SETUP_DEF    = 2;
   localparam int CS_HOLD_DEF     = 2;
   localparam int ACK_TIMEOUT_DEF = 16;

   // Largest of three values; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // One-hot select of a client (bit N for client N).
   function automatic logic [1:0] client_onehot(input logic c);
      return c ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/spi_arbiter.sv
// Two-client arbiter in front of a single spi_master byte interface.
// Grants the bus round-robin, frames each grant with its own chip select
// (setup and hold time around the bytes), and forwards one byte at a time.
//
// Handshakes:
//   client side : reqN held high for the whole transaction; gntN marks
//                 ownership. A byte is accepted only when rdyN is high and
//                 wrN is strobed for one cycle (dinN sampled with it); the
//                 reply is valid on dout in the cycle doneN pulses.
//   master side : m_write is held high until m_busy is sampled high (the
//                 master accepted the byte); the byte is finished when
//                 m_busy is next sampled low, and m_dout is captured then.
//                 If m_busy never rises within ACK_TIMEOUT cycles the byte
//                 is abandoned, err pulses, and the chip select is released.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int CS_SETUP    = CS_SETUP_DEF,
   parameter int CS_HOLD     = CS_HOLD_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic       wr0,
   input  logic       wr1,
   input  logic [7:0] din0,
   input  logic [7:0] din1,
   output logic       rdy0,
   output logic       rdy1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] dout,
   output logic       err,
   output logic [7:0] m_din,
   output logic       m_write,
   input  logic       m_busy,
   input  logic [7:0] m_dout,
   output logic [1:0] cs_n,
   output spi_state_t dbg_state
);

   localparam int CNT_MAX = max3(CS_SETUP, CS_HOLD, ACK_TIMEOUT);
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   spi_state_t       state;
   logic [CNT_W-1:0] cnt;        // shared by setup, hold and ack timeout
   logic             owner;      // client currently holding the bus
   logic             last_grant; // client granted most recently
   logic [1:0]       gnt;
   logic [1:0]       rdy;
   logic [1:0]       done;

   logic             next_owner;
   logic             req_sel;
   logic             wr_sel;
   logic [7:0]       din_sel;
   logic             cnt_last;

   // Round-robin pick: under contention the client not granted last wins.
   assign next_owner = (req0 && req1) ? ~last_grant : req1;

   // Inputs of the owning client; the other client's strobes never reach the FSM.
   assign req_sel  = owner ? req1 : req0;
   assign wr_sel   = owner ? wr1  : wr0;
   assign din_sel  = owner ? din1 : din0;

   // A count of 0 or 1 ends the phase, so a zero parameter still lasts one cycle.
   assign cnt_last = (cnt <= CNT_W'(1));

   assign gnt0      = gnt[0];
   assign gnt1      = gnt[1];
   assign rdy0      = rdy[0];
   assign rdy1      = rdy[1];
   assign done0     = done[0];
   assign done1     = done[1];
   assign dbg_state = state;

   // Arbiter FSM with all client and master outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         gnt        <= 2'b00;
         rdy        <= 2'b00;
         done       <= 2'b00;
         err        <= 1'b0;
         cs_n       <= 2'b11;
         m_write    <= 1'b0;
         m_din      <= 8'h00;
         dout       <= 8'h00;
      end else begin
         done <= 2'b00;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner      <= next_owner;
                  last_grant <= next_owner;
                  gnt        <= client_onehot(next_owner);
                  cs_n       <= ~client_onehot(next_owner);
                  cnt        <= CNT_W'(CS_SETUP);
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_last) begin
                  rdy   <= client_onehot(owner);
                  state <= READY;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            READY: begin
               // A write beats a dropped request in the same cycle.
               if (wr_sel) begin
                  m_din   <= din_sel;
                  m_write <= 1'b1;
                  rdy     <= 2'b00;
                  cnt     <= CNT_W'(ACK_TIMEOUT);
                  state   <= START;
               end else if (!req_sel) begin
                  rdy   <= 2'b00;
                  cnt   <= CNT_W'(CS_HOLD);
                  state <= HOLD;
               end
            end
            START: begin
               if (m_busy) begin
                  m_write <= 1'b0;
                  state   <= XFER;
               end else if (cnt_last) begin
                  m_write <= 1'b0;
                  err     <= 1'b1;
                  cnt     <= CNT_W'(CS_HOLD);
                  state   <= HOLD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            XFER: begin
               // A request dropped mid-byte only takes effect once the byte is done.
               if (!m_busy) begin
                  dout <= m_dout;
                  done <= client_onehot(owner);
                  if (req_sel) begin
                     rdy   <= client_onehot(owner);
                     state <= READY;
                  end else begin
                     cnt   <= CNT_W'(CS_HOLD);
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Release lands in IDLE, which always lasts a cycle before the next grant.
               if (cnt_last) begin
                  cs_n  <= 2'b11;
                  gnt   <= 2'b00;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural spi_master stand-in
// that answers each byte with (m_din ^ slave_key) after a short busy period.
module tb_spi_arbiter;
   import spi_pkg::*;

   localparam int CS_SETUP    = 2;
   localparam int CS_HOLD     = 2;
   localparam int ACK_TIMEOUT = 16;

   localparam int P_RDY0  = 0;
   localparam int P_RDY1  = 1;
   localparam int P_DONE0 = 2;
   localparam int P_DONE1 = 3;
   localparam int P_ERR   = 4;
   localparam int P_CSOFF = 5;
   localparam int P_MWR   = 6;
   localparam int P_XFER  = 7;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       req0, req1, wr0, wr1;
   logic [7:0] din0, din1;
   logic       gnt0, gnt1, rdy0, rdy1, done0, done1, err;
   logic [7:0] dout, m_din, m_dout;
   logic       m_write, m_busy;
   logic [1:0] cs_n;
   spi_state_t dbg_state;

   spi_arbiter #(
      .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .wr0(wr0), .wr1(wr1), .din0(din0), .din1(din1),
      .rdy0(rdy0), .rdy1(rdy1), .done0(done0), .done1(done1),
      .dout(dout), .err(err),
      .m_din(m_din), .m_write(m_write), .m_busy(m_busy), .m_dout(m_dout),
      .cs_n(cs_n), .dbg_state(dbg_state)
   );

   // ---------------- slave model ----------------
   logic       slave_en;
   logic [7:0] slave_key;
   int         sl_cnt;
   logic [7:0] seen_q[$];
   logic [7:0] exp_q[$];

   // Accept a byte one cycle after m_write, stay busy four cycles, then reply.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_dout <= 8'h00;
         sl_cnt <= 0;
      end else if (sl_cnt != 0) begin
         sl_cnt <= sl_cnt - 1;
         if (sl_cnt == 1) m_busy <= 1'b0;
      end else if (m_write && slave_en && !m_busy) begin
         m_busy <= 1'b1;
         sl_cnt <= 4;
         m_dout <= m_din ^ slave_key;
         seen_q.push_back(m_din);
      end
   end

   // ---------------- scoreboard ----------------
   int vecs  = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Exclusivity of grants and chip selects, checked every cycle.
   always @(negedge clk) begin
      check("gnt_onehot", 32'($onehot0({gnt1, gnt0})), 32'd1);
      check("cs_not_both", 32'(cs_n != 2'b00), 32'd1);
   end

   function automatic logic probe(input int sel);
      case (sel)
         P_RDY0:  return rdy0;
         P_RDY1:  return rdy1;
         P_DONE0: return done0;
         P_DONE1: return done1;
         P_ERR:   return err;
         P_CSOFF: return cs_n == 2'b11;
         P_MWR:   return m_write;
         P_XFER:  return dbg_state == XFER;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_for(input int sel, input int budget, input string tag, output int cyc);
      cyc = 0;
      while (!probe(sel) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(probe(sel)), 32'd1);
   endtask

   task automatic strobe(input int c, input logic [7:0] d);
      if (c == 0) begin wr0 = 1'b1; din0 = d; end
      else        begin wr1 = 1'b1; din1 = d; end
      @(negedge clk);
      wr0 = 1'b0;
      wr1 = 1'b0;
   endtask

   task automatic send_byte(input int c, input logic [7:0] d, input logic [7:0] exp_dout,
                            input string tag);
      int cyc;
      logic [7:0] got;
      wait_for(c == 0 ? P_RDY0 : P_RDY1, 20, {tag, "_rdy"}, cyc);
      exp_q.push_back(d);
      strobe(c, d);
      wait_for(c == 0 ? P_DONE0 : P_DONE1, 40, {tag, "_done"}, cyc);
      check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
      got = (seen_q.size() > 0) ? seen_q.pop_front() : 8'hxx;
      check({tag, "_mdin"}, 32'(got), 32'(exp_q.pop_front()));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      din0 = 8'h00; din1 = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen_q.delete();
      exp_q.delete();
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      int ndone;
      slave_en  = 1'b1;
      slave_key = 8'h99;
      do_reset();
      reset = 1'b1;
      @(negedge clk);
      check("rst_cs_n", 32'(cs_n), 32'h3);
      check("rst_gnt", 32'({gnt1, gnt0}), 32'h0);
      check("rst_rdy_done_err", 32'({rdy1, rdy0, done1, done0, err}), 32'h0);
      check("rst_mwrite_mdin_dout", 32'({m_write, m_din, dout}), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      reset = 1'b0;
      @(negedge clk);

      // Client 0 alone: A5 out, 3C back (A5 ^ 99).
      req0 = 1'b1;
      @(negedge clk);
      check("c0_gnt", 32'({gnt1, gnt0}), 32'h1);
      check("c0_cs_low", 32'(cs_n), 32'h2);
      wait_for(P_RDY0, 10, "c0_setup", cyc);
      check("c0_setup_len", 32'(cyc), 32'(CS_SETUP));
      send_byte(0, 8'hA5, 8'h3C, "c0");
      check("c0_cs_during", 32'(cs_n), 32'h2);
      req0 = 1'b0;
      @(negedge clk);
      check("c0_done_pulse", 32'(done0), 32'h0);
      wait_for(P_CSOFF, 10, "c0_release", cyc);
      check("c0_hold_len", 32'(cyc), 32'(CS_HOLD));
      check("c0_gnt_clear", 32'({gnt1, gnt0}), 32'h0);

      // Simultaneous requests after reset: client 0 first, then client 1.
      do_reset();
      slave_key = 8'h0F;
      req0 = 1'b1;
      req1 = 1'b1;
      @(negedge clk);
      check("rr1_gnt0", 32'({gnt1, gnt0}), 32'h1);
      wait_for(P_RDY0, 10, "rr1_rdy0", cyc);
      strobe(1, 8'hFF);  // non-owner strobe must be ignored
      check("ign_wr1_state", 32'(dbg_state), 32'(READY));
      check("ign_wr1_mdin", 32'({m_write, m_din}), 32'h0);
      send_byte(0, 8'h10, 8'h1F, "rr1_c0");
      req0 = 1'b0;
      wait_for(P_CSOFF, 10, "rr1_rel0", cyc);
      check("rr1_idle_gap", 32'({dbg_state, gnt1, gnt0}), 32'({IDLE, 2'b00}));
      req0 = 1'b1;  // both requesting again: client 1 is next
      @(negedge clk);
      check("rr2_gnt1", 32'({gnt1, gnt0}), 32'h2);
      check("rr2_cs1", 32'(cs_n), 32'h1);
      send_byte(1, 8'h20, 8'h2F, "rr2_c1");
      req1 = 1'b0;
      wait_for(P_CSOFF, 10, "rr2_rel1", cyc);
      @(negedge clk);
      check("rr3_gnt0", 32'({gnt1, gnt0}), 32'h1);
      send_byte(0, 8'h30, 8'h3F, "rr3_c0");
      req0 = 1'b0;
      wait_for(P_CSOFF, 10, "rr3_rel0", cyc);

      // Client 1 sends three bytes back-to-back under one chip select.
      do_reset();
      slave_key = 8'h55;
      req1 = 1'b1;
      @(negedge clk);
      strobe(1, 8'hEE);  // strobe while rdy1 is low must be ignored
      check("ign_early_wr", 32'({m_write, m_din}), 32'h0);
      send_byte(1, 8'h01, 8'h54, "b1");
      check("b1_cs", 32'(cs_n), 32'h1);
      send_byte(1, 8'h02, 8'h57, "b2");
      check("b2_cs", 32'(cs_n), 32'h1);
      send_byte(1, 8'h03, 8'h56, "b3");
      check("b3_cs", 32'(cs_n), 32'h1);
      req1 = 1'b0;
      wait_for(P_CSOFF, 10, "b_release", cyc);

      // Master never acknowledges: err exactly ACK_TIMEOUT cycles after m_write.
      slave_en = 1'b0;
      req0 = 1'b1;
      wait_for(P_RDY0, 10, "to_rdy", cyc);
      strobe(0, 8'h77);
      wait_for(P_MWR, 5, "to_mwrite", cyc);
      wait_for(P_ERR, 40, "to_err", cyc);
      check("to_err_delay", 32'(cyc), 32'(ACK_TIMEOUT));
      check("to_mwrite_low", 32'(m_write), 32'h0);
      req0 = 1'b0;
      @(negedge clk);
      check("to_err_pulse", 32'(err), 32'h0);
      wait_for(P_CSOFF, 10, "to_release", cyc);
      slave_en = 1'b1;

      // Request dropped mid-byte: the byte still completes, then release.
      slave_key = 8'hF0;
      req0 = 1'b1;
      wait_for(P_RDY0, 10, "drop_rdy", cyc);
      exp_q.push_back(8'h5A);
      strobe(0, 8'h5A);
      wait_for(P_XFER, 10, "drop_xfer", cyc);
      req0 = 1'b0;
      wait_for(P_DONE0, 20, "drop_done", cyc);
      check("drop_dout", 32'(dout), 32'hAA);
      check("drop_mdin", 32'(seen_q.pop_front()), 32'(exp_q.pop_front()));
      check("drop_state_hold", 32'(dbg_state), 32'(HOLD));
      wait_for(P_CSOFF, 10, "drop_release", cyc);
      check("drop_gnt_clear", 32'(gnt0), 32'h0);

      // Reset during XFER forces outputs at once; no done follows.
      req0 = 1'b1;
      wait_for(P_RDY0, 10, "rx_rdy", cyc);
      strobe(0, 8'hC3);
      wait_for(P_XFER, 10, "rx_xfer", cyc);
      reset = 1'b1;
      #1;
      check("rx_cs_n", 32'(cs_n), 32'h3);
      check("rx_mwrite_gnt", 32'({m_write, gnt1, gnt0}), 32'h0);
      check("rx_state", 32'(dbg_state), 32'(IDLE));
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) begin
            req0  = 1'b0;
            reset = 1'b0;
         end
         if (done0 || done1) ndone++;
      end
      check("rx_no_done", 32'(ndone), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
